hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
Central pipeline hazard controller. It generates the stall, hold and flush controls consumed by the PC, IF/ID, ID/EX and EX/MEM pipeline registers. It detects load-use and branch-operand hazards, squashes the fetched instruction on a taken branch or jump, and sequences a multi-cycle multiply that occupies EX. It sits beside the ID stage and takes register numbers and control bits from the ID, EX and MEM stages.

Parameters:
MUL_LATENCY, 4, total EX-stage cycles taken by a mulOp instruction; legal range 2..15.
CNT_W, 4, width of the multiply cycle counter; must satisfy 2^CNT_W > MUL_LATENCY.

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  synchronous, active-high reset
ID_rs  in  5  rs field of the instruction in ID
ID_rt  in  5  rt field of the instruction in ID
ID_usesRt  in  1  ID instruction reads rt as a source
ID_branch  in  1  ID instruction is a branch that compares registers in ID
branchTaken  in  1  branch or jump in ID resolved as taken
EX_MemRead  in  1  instruction in EX is a load
EX_regWrite  in  1  instruction in EX writes a register
EX_writeReg  in  5  destination register of the EX instruction, after the regDst/jal mux
EX_mulOp  in  1  instruction in EX is a multi-cycle multiply
MEM_MemRead  in  1  instruction in MEM is a load
MEM_writeReg  in  5  destination register of the MEM instruction
PCWrite  out  1  PC update enable
IF_ID_Write  out  1  IF/ID register load enable
IF_ID_flush  out  1  zero the IF/ID register on the next edge
ID_EX_Write  out  1  ID/EX register load enable
ID_EX_flush  out  1  insert a bubble into ID/EX
EX_MEM_flush  out  1  insert a bubble into EX/MEM
mul_done  out  1  high in the final EX cycle of a multiply

Behaviour:
- Reset: synchronous, active-high. While reset=1:
  - PCWrite=0, IF_ID_Write=0, ID_EX_Write=1.
  - IF_ID_flush=1, ID_EX_flush=1, EX_MEM_flush=1, mul_done=0.
  - On the edge, state<=RUN and cnt<=0.
- Reset during MUL_WAIT or MUL_LAST aborts the multiply; the unit is in RUN on the next cycle.
- Outputs are combinational from the registered state and the current inputs, so the pipeline registers act on the same edge. No added latency.
- Register 0 never causes a hazard: every match below requires the register number to be nonzero.
- Load-use hazard (LU): EX_MemRead and EX_writeReg matches ID_rs, or matches ID_rt with ID_usesRt=1.
- Branch hazard (BR): ID_branch=1 and one of:
  - EX_regWrite and EX_writeReg matches a source of the ID instruction;
  - MEM_MemRead and MEM_writeReg matches a source of the ID instruction.
- States:
  - RUN: normal operation.
  - MUL_WAIT: multiply in progress; cnt counts the remaining hold cycles.
  - MUL_LAST: the multiply's final EX cycle.
- Default outputs (no event): PCWrite=1, IF_ID_Write=1, ID_EX_Write=1, all flushes=0, mul_done=0.
- Priority, highest first: reset, multiply hold, stall (LU or BR), taken-branch flush.
- RUN with EX_mulOp=1 (multiply hold):
  - Outputs: PCWrite=0, IF_ID_Write=0, ID_EX_Write=0, EX_MEM_flush=1.
  - cnt<=MUL_LATENCY-2.
  - Next state is MUL_LAST if MUL_LATENCY==2, else MUL_WAIT.
  - LU, BR and branchTaken are ignored this cycle.
- MUL_WAIT:
  - Same hold outputs as the RUN multiply entry.
  - cnt<=cnt-1; when cnt==1, next state is MUL_LAST.
- MUL_LAST:
  - mul_done=1; hold is released.
  - LU, BR and branchTaken are evaluated as in RUN.
  - EX_mulOp is ignored (it is the same instruction). Next state is RUN.
  - Total EX occupancy of a multiply is exactly MUL_LATENCY cycles, with MUL_LATENCY-1 of them held.
- Stall (LU or BR, not holding):
  - PCWrite=0, IF_ID_Write=0, ID_EX_flush=1.
  - branchTaken is suppressed: IF_ID_flush=0, because the branch re-resolves next cycle.
- Taken branch (branchTaken, no stall, no hold): IF_ID_flush=1 for that single cycle; PCWrite stays 1.
- A flush always wins over a write on the same register: ID_EX_flush=1 clears even if ID_EX_Write=1.

Decomposition:
- Shared package hazard_pkg holds:
  - the state enum RUN=2'd0, MUL_WAIT=2'd1, MUL_LAST=2'd2;
  - the REG_ZERO constant (5'd0);
  - the register-field width constant (5).
- One sub-module, hazard_reg_match: pure compare of one source register against one destination register, with the nonzero check. Instantiated 6 times.
- FSM, counter and output mux stay in hazard_ctrl_unit.

Test Plan:
- Load-use: EX_MemRead=1, EX_writeReg=8, ID_rs=8 for one cycle -> PCWrite=0, IF_ID_Write=0, ID_EX_flush=1 that cycle; all defaults the next cycle once EX_MemRead=0.
- Register-zero guard: EX_MemRead=1, EX_writeReg=0, ID_rs=0 -> no stall; ID_rt=9 match with ID_usesRt=0 -> no stall.
- Branch hazard: ID_branch=1, MEM_MemRead=1, MEM_writeReg=5, ID_rt=5, ID_usesRt=1, branchTaken=1 -> stall asserted, IF_ID_flush=0; remove the hazard next cycle -> IF_ID_flush=1, PCWrite=1.
- Multiply, MUL_LATENCY=4: EX_mulOp=1 held.
  - Cycles 0-2: PCWrite=0, ID_EX_Write=0, EX_MEM_flush=1.
  - Cycle 3: mul_done=1 and hold released.
  - Cycle 4: RUN.
  - Repeat with MUL_LATENCY=2: 1 hold cycle, then mul_done.
- Simultaneous events: EX_mulOp=1 together with an LU condition and branchTaken=1 in RUN -> only the hold outputs; ID_EX_flush=0, IF_ID_flush=0.
- Reset mid-multiply: assert reset at cycle 1 of a multiply.
  - During reset: all flushes=1, PCWrite=0, mul_done=0.
  - After reset with EX_mulOp=0: default outputs.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MUL_WAIT = 2'd1,
        MUL_LAST = 2'd2
    } hazard_state_e;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-side view of the hazard controller: stage register/control inputs and
// the stall, hold and flush controls it returns.
interface hazard_ctrl_unit_if;
    import hazard_pkg::*;

    logic [REG_W-1:0] ID_rs;
    logic [REG_W-1:0] ID_rt;
    logic             ID_usesRt;
    logic             ID_branch;
    logic             branchTaken;
    logic             EX_MemRead;
    logic             EX_regWrite;
    logic [REG_W-1:0] EX_writeReg;
    logic             EX_mulOp;
    logic             MEM_MemRead;
    logic [REG_W-1:0] MEM_writeReg;

    logic PCWrite;
    logic IF_ID_Write;
    logic IF_ID_flush;
    logic ID_EX_Write;
    logic ID_EX_flush;
    logic EX_MEM_flush;
    logic mul_done;

    modport master (
        output ID_rs, ID_rt, ID_usesRt, ID_branch, branchTaken,
        output EX_MemRead, EX_regWrite, EX_writeReg, EX_mulOp,
        output MEM_MemRead, MEM_writeReg,
        input  PCWrite, IF_ID_Write, IF_ID_flush, ID_EX_Write, ID_EX_flush,
        input  EX_MEM_flush, mul_done
    );

    modport slave (
        input  ID_rs, ID_rt, ID_usesRt, ID_branch, branchTaken,
        input  EX_MemRead, EX_regWrite, EX_writeReg, EX_mulOp,
        input  MEM_MemRead, MEM_writeReg,
        output PCWrite, IF_ID_Write, IF_ID_flush, ID_EX_Write, ID_EX_flush,
        output EX_MEM_flush, mul_done
    );

endinterface

// File: rtl/hazard_reg_match.sv
// Compares one source register against one destination register; r0 never matches.
module hazard_reg_match
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] src_i,
    input  logic [REG_W-1:0] dst_i,
    output logic             match_o
);

    assign match_o = (src_i == dst_i) && (dst_i != REG_ZERO);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use and branch-operand stalls, taken-branch
// squash, and multi-cycle multiply hold sequencing.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 4,
    parameter int unsigned CNT_W       = 4
) (
    input logic               clk,
    input logic               reset,
    hazard_ctrl_unit_if.slave bus
);

    hazard_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic lu_rs, lu_rt, br_ex_rs, br_ex_rt, br_mem_rs, br_mem_rt;

    hazard_reg_match u_lu_rs (.src_i(bus.ID_rs), .dst_i(bus.EX_writeReg),  .match_o(lu_rs));
    hazard_reg_match u_lu_rt (.src_i(bus.ID_rt), .dst_i(bus.EX_writeReg),  .match_o(lu_rt));
    hazard_reg_match u_br_ex_rs (.src_i(bus.ID_rs), .dst_i(bus.EX_writeReg), .match_o(br_ex_rs));
    hazard_reg_match u_br_ex_rt (.src_i(bus.ID_rt), .dst_i(bus.EX_writeReg), .match_o(br_ex_rt));
    hazard_reg_match u_br_mem_rs (.src_i(bus.ID_rs), .dst_i(bus.MEM_writeReg), .match_o(br_mem_rs));
    hazard_reg_match u_br_mem_rt (.src_i(bus.ID_rt), .dst_i(bus.MEM_writeReg), .match_o(br_mem_rt));

    logic lu_haz, br_haz, stall, hold;

    assign lu_haz = bus.EX_MemRead && (lu_rs || (lu_rt && bus.ID_usesRt));
    assign br_haz = bus.ID_branch &&
                    ((bus.EX_regWrite && (br_ex_rs || (br_ex_rt && bus.ID_usesRt))) ||
                     (bus.MEM_MemRead && (br_mem_rs || (br_mem_rt && bus.ID_usesRt))));
    assign stall  = lu_haz || br_haz;
    // In MUL_LAST the multiply is still in EX, so its mulOp must not restart the hold.
    assign hold   = ((state_q == RUN) && bus.EX_mulOp) || (state_q == MUL_WAIT);

    logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_flush, mul_done;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mul_done     = 1'b0;

        case (state_q)
            RUN: begin
                if (bus.EX_mulOp) begin
                    cnt_d   = CNT_W'(MUL_LATENCY - 2);
                    state_d = (MUL_LATENCY == 2) ? MUL_LAST : MUL_WAIT;
                end
            end
            MUL_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = MUL_LAST;
                end
            end
            MUL_LAST: begin
                mul_done = 1'b1;
                state_d  = RUN;
            end
            default: state_d = RUN;
        endcase

        if (reset) begin
            state_d      = RUN;
            cnt_d        = '0;
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_write  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mul_done     = 1'b0;
        end else if (hold) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_flush = 1'b1;
        end else if (stall) begin
            // Taken flag is dropped: the branch re-resolves once operands are ready.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end else if (bus.branchTaken) begin
            if_id_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.PCWrite      = pc_write;
    assign bus.IF_ID_Write  = if_id_write;
    assign bus.IF_ID_flush  = if_id_flush;
    assign bus.ID_EX_Write  = id_ex_write;
    assign bus.ID_EX_flush  = id_ex_flush;
    assign bus.EX_MEM_flush = ex_mem_flush;
    assign bus.mul_done     = mul_done;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit at MUL_LATENCY 4 and 2.
module tb_hazard_ctrl_unit;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    hazard_ctrl_unit_if bus4 ();
    hazard_ctrl_unit_if bus2 ();

    hazard_ctrl_unit #(.MUL_LATENCY(4), .CNT_W(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
    hazard_ctrl_unit #(.MUL_LATENCY(2), .CNT_W(4)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCWrite, IF_ID_Write, IF_ID_flush, ID_EX_Write, ID_EX_flush, EX_MEM_flush, mul_done}
    localparam logic [6:0] DEF   = 7'b1101000;
    localparam logic [6:0] RST   = 7'b0011110;
    localparam logic [6:0] HOLD  = 7'b0000010;
    localparam logic [6:0] STALL = 7'b0001100;
    localparam logic [6:0] BRFL  = 7'b1111000;
    localparam logic [6:0] DONE  = 7'b1101001;
    localparam logic [6:0] DONE_BRFL = 7'b1111001;
    localparam logic [6:0] DONE_STALL = 7'b0001101;

    function automatic logic [6:0] obs4();
        return {bus4.PCWrite, bus4.IF_ID_Write, bus4.IF_ID_flush, bus4.ID_EX_Write,
                bus4.ID_EX_flush, bus4.EX_MEM_flush, bus4.mul_done};
    endfunction

    function automatic logic [6:0] obs2();
        return {bus2.PCWrite, bus2.IF_ID_Write, bus2.IF_ID_flush, bus2.ID_EX_Write,
                bus2.ID_EX_flush, bus2.EX_MEM_flush, bus2.mul_done};
    endfunction

    task automatic chk4(input string tag, input logic [6:0] exp);
        logic [6:0] o;
        #2;
        o = obs4();
        tests++;
        assert (o === exp) else begin
            fails++;
            $error("FAIL %s (L4): observed %b expected %b", tag, o, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [6:0] exp);
        logic [6:0] o;
        #2;
        o = obs2();
        tests++;
        assert (o === exp) else begin
            fails++;
            $error("FAIL %s (L2): observed %b expected %b", tag, o, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle4();
        bus4.ID_rs = '0;        bus4.ID_rt = '0;         bus4.ID_usesRt = 1'b0;
        bus4.ID_branch = 1'b0;  bus4.branchTaken = 1'b0; bus4.EX_MemRead = 1'b0;
        bus4.EX_regWrite = 1'b0; bus4.EX_writeReg = '0;  bus4.EX_mulOp = 1'b0;
        bus4.MEM_MemRead = 1'b0; bus4.MEM_writeReg = '0;
    endtask

    task automatic idle2();
        bus2.ID_rs = '0;        bus2.ID_rt = '0;         bus2.ID_usesRt = 1'b0;
        bus2.ID_branch = 1'b0;  bus2.branchTaken = 1'b0; bus2.EX_MemRead = 1'b0;
        bus2.EX_regWrite = 1'b0; bus2.EX_writeReg = '0;  bus2.EX_mulOp = 1'b0;
        bus2.MEM_MemRead = 1'b0; bus2.MEM_writeReg = '0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        idle4();
        idle2();

        tick();
        chk4("reset_outputs", RST);
        chk2("reset_outputs", RST);
        tick();
        reset = 1'b0;
        chk4("post_reset_default", DEF);
        chk2("post_reset_default", DEF);

        // Load-use on rs, then clears
        bus4.EX_MemRead = 1'b1; bus4.EX_writeReg = 5'd8; bus4.ID_rs = 5'd8;
        chk4("lu_rs_stall", STALL);
        tick();
        idle4();
        chk4("lu_cleared", DEF);

        // Register-zero guard and usesRt qualification
        bus4.EX_MemRead = 1'b1; bus4.EX_writeReg = 5'd0; bus4.ID_rs = 5'd0;
        chk4("lu_r0_no_stall", DEF);
        tick();
        bus4.EX_writeReg = 5'd9; bus4.ID_rt = 5'd9; bus4.ID_usesRt = 1'b0;
        chk4("lu_rt_unused", DEF);
        tick();
        bus4.ID_usesRt = 1'b1;
        chk4("lu_rt_used", STALL);
        tick();
        idle4();

        // Branch hazard on MEM load suppresses the taken flush, then flush fires
        bus4.ID_branch = 1'b1; bus4.MEM_MemRead = 1'b1; bus4.MEM_writeReg = 5'd5;
        bus4.ID_rt = 5'd5; bus4.ID_usesRt = 1'b1; bus4.branchTaken = 1'b1;
        chk4("br_mem_stall", STALL);
        tick();
        bus4.MEM_MemRead = 1'b0;
        chk4("br_taken_flush", BRFL);
        tick();
        idle4();
        bus4.ID_branch = 1'b1; bus4.EX_regWrite = 1'b1; bus4.EX_writeReg = 5'd7;
        bus4.ID_rs = 5'd7;
        chk4("br_ex_stall", STALL);
        tick();
        bus4.ID_branch = 1'b0;
        chk4("no_branch_no_stall", DEF);
        tick();
        idle4();

        // Multiply, latency 4: three held cycles, then done with LU evaluated
        bus4.EX_mulOp = 1'b1;
        chk4("mul4_c0", HOLD);
        tick();
        chk4("mul4_c1", HOLD);
        tick();
        chk4("mul4_c2", HOLD);
        tick();
        bus4.EX_MemRead = 1'b1; bus4.EX_writeReg = 5'd3; bus4.ID_rs = 5'd3;
        chk4("mul4_c3_done_stall", DONE_STALL);
        tick();
        idle4();
        chk4("mul4_c4_run", DEF);
        tick();

        // Multiply, latency 2: one held cycle, then done with taken branch
        bus2.EX_mulOp = 1'b1;
        chk2("mul2_c0", HOLD);
        tick();
        bus2.branchTaken = 1'b1;
        chk2("mul2_c1_done_flush", DONE_BRFL);
        tick();
        bus2.branchTaken = 1'b0;
        chk2("mul2_c2_reenter", HOLD);
        tick();
        idle2();
        chk2("mul2_c3_done", DONE);
        tick();
        chk2("mul2_idle", DEF);

        // Multiply entry masks LU and taken branch; reset aborts mid-multiply
        bus4.EX_mulOp = 1'b1; bus4.EX_MemRead = 1'b1; bus4.EX_writeReg = 5'd4;
        bus4.ID_rs = 5'd4; bus4.branchTaken = 1'b1;
        chk4("mul_masks_events", HOLD);
        tick();
        bus4.EX_MemRead = 1'b0; bus4.branchTaken = 1'b0;
        reset = 1'b1;
        chk4("reset_mid_mul", RST);
        tick();
        reset = 1'b0;
        idle4();
        chk4("after_reset_run", DEF);
        tick();
        chk4("after_reset_run2", DEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
